// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC, imem req/ack handshake, IF/ID register.
// Optional retired-fetch counter enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_f,
  input  logic              stall_d,
  input  logic              flush_d,
  input  logic [1:0]        pc_src_d,
  input  logic [ADDR_W-1:0] branch_target_d,
  input  logic [ADDR_W-1:0] jump_target_d,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instr_d,
  output logic [ADDR_W-1:0] pc_plus4_d,
  output logic              valid_d,
  output logic              fetch_busy,
  output logic [31:0]       fetch_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]        state_q, state_n;
  logic [ADDR_W-1:0] pc_q, pc_n, pc_inc;
  logic              pend_q, pend_n;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_n;
  logic [DATA_W-1:0] hold_instr_q;
  logic [ADDR_W-1:0] hold_pc4_q;
  logic              buf_we;
  logic              load_en;
  logic [DATA_W-1:0] load_instr;
  logic [ADDR_W-1:0] load_pc4;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_tgt;

  assign pc_inc       = pc_q + ADDR_W'(4);
  assign redirect     = !stall_f && (pc_src_d != 2'b00);
  assign redirect_tgt = (pc_src_d == 2'b01) ? branch_target_d : jump_target_d;

  assign imem_req   = (state_q == S_FETCH);
  assign imem_addr  = pc_q;
  assign fetch_busy = (state_q == S_IDLE) || ((state_q == S_FETCH) && !imem_ack);

  // load_instr/load_pc4 stay zero when nothing is delivered, so IF/ID takes a NOP
  always_comb begin
    state_n    = state_q;
    pc_n       = pc_q;
    pend_n     = pend_q;
    pend_tgt_n = pend_tgt_q;
    buf_we     = 1'b0;
    load_en    = 1'b0;
    load_instr = '0;
    load_pc4   = '0;
    case (state_q)
      S_IDLE: state_n = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          if (stall_f) begin
            buf_we  = 1'b1;
            state_n = S_HOLD;
          end else if (redirect) begin
            pc_n   = redirect_tgt;
            pend_n = 1'b0;
          end else if (pend_q) begin
            pc_n   = pend_tgt_q;
            pend_n = 1'b0;
          end else begin
            load_en    = 1'b1;
            load_instr = imem_rdata;
            load_pc4   = pc_inc;
            pc_n       = pc_inc;
          end
        end else if (redirect) begin
          pend_n     = 1'b1;
          pend_tgt_n = redirect_tgt;
        end
      end
      S_HOLD: begin
        if (!stall_f) begin
          state_n = S_FETCH;
          if (redirect) begin
            pc_n   = redirect_tgt;
            pend_n = 1'b0;
          end else if (pend_q) begin
            pc_n   = pend_tgt_q;
            pend_n = 1'b0;
          end else begin
            load_en    = 1'b1;
            load_instr = hold_instr_q;
            load_pc4   = hold_pc4_q;
            pc_n       = pc_inc;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      pend_q       <= 1'b0;
      pend_tgt_q   <= '0;
      hold_instr_q <= '0;
      hold_pc4_q   <= '0;
    end else begin
      state_q    <= state_n;
      pc_q       <= pc_n;
      pend_q     <= pend_n;
      pend_tgt_q <= pend_tgt_n;
      if (buf_we) begin
        hold_instr_q <= imem_rdata;
        hold_pc4_q   <= pc_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_d    <= '0;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end else if (flush_d) begin
      instr_d    <= '0;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end else if (!stall_d) begin
      instr_d    <= load_instr;
      pc_plus4_d <= load_pc4;
      valid_d    <= load_en;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic        cnt_inc;
  logic [31:0] fetch_cnt_q;

  assign cnt_inc = load_en && !flush_d && !stall_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q <= '0;
    end else if (cnt_inc) begin
      fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
`else
  assign fetch_cnt = '0;
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch front end of the five-stage pipeline: owns the program counter, issues requests to instruction memory over a req/ack handshake, and loads the IF/ID pipeline register. It consumes the stall, flush and next-PC controls produced by the hazard unit and the decode-stage branch/jump logic. It reports memory wait cycles back through `fetch_busy` so the hazard unit can freeze the rest of the front end.

## Interface
- `ADDR_W`, 32, PC and memory address width.
- `DATA_W`, 32, instruction word width.
- `RESET_PC`, 0, PC value loaded on reset.

- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `stall_f` in 1: hold the PC and refuse redirects this cycle.
- `stall_d` in 1: hold the IF/ID register.
- `flush_d` in 1: clear the IF/ID register to NOP. Has priority over `stall_d`.
- `pc_src_d` in 2: next-PC select.
  - 00: sequential.
  - 01: branch.
  - 10: jump.
  - 11: jump register.
- `branch_target_d` in ADDR_W: branch target.
- `jump_target_d` in ADDR_W: target for both jump and jump register.
- `imem_req` out 1: fetch request.
- `imem_addr` out ADDR_W: fetch address. Stable while `imem_req` is high.
- `imem_ack` in 1: read data valid this cycle.
- `imem_rdata` in DATA_W: instruction word.
- `instr_d` out DATA_W: IF/ID instruction.
- `pc_plus4_d` out ADDR_W: IF/ID PC+4.
- `valid_d` out 1: IF/ID holds a real instruction.
- `fetch_busy` out 1: front end waiting on memory.
- `fetch_cnt` out 32: instructions delivered to IF/ID (see Configuration).

## Operation
- States: IDLE, FETCH, HOLD. Reset enters IDLE. IDLE moves to FETCH on the next clock.
- IDLE: `imem_req`=0, `fetch_busy`=1.
- FETCH:
  - `imem_req`=1 and `imem_addr`=pc.
  - Redirect accepted when `stall_f`=0 and `pc_src_d`≠00.
    - Target is `branch_target_d` for 01, otherwise `jump_target_d`.
- FETCH, ack=1, `stall_f`=0:
  - If a redirect is accepted this cycle, or one is pending:
    - Discard the word; IF/ID ← NOP, `valid_d`=0 (when `stall_d`=0).
    - pc ← target; pending cleared.
    - A same-cycle redirect wins over a pending one.
  - Otherwise:
    - IF/ID ← {`imem_rdata`, pc+4}, `valid_d`=1 (when `stall_d`=0).
    - pc ← pc+4.
  - Stay in FETCH; the new request appears the next cycle.
- FETCH, ack=1, `stall_f`=1:
  - Word and pc+4 go to the hold buffer.
  - Go to HOLD.
  - pc unchanged; a pending redirect stays pending.
- FETCH, ack=0, `stall_f`=0 with redirect:
  - Latch the target into pending. A later redirect overwrites it.
  - pc and `imem_addr` stay unchanged until ack.
- HOLD: `imem_req`=0. Wait for `stall_f`=0, then:
  - If a redirect (current or pending) exists: drop the buffer, pc ← target.
  - Otherwise: IF/ID ← buffer (when `stall_d`=0), pc ← pc+4.
  - Go to FETCH.
- IF/ID register:
  - `flush_d` → instr 0, pc_plus4 0, valid 0.
  - Else `stall_d` → hold.
  - Else load as above. In cycles with no load source, IF/ID ← NOP with `valid_d`=0.
- pc arithmetic is modulo 2^ADDR_W: 0xFFFF_FFFC+4 wraps to 0.

## Timing
- Reset values:
  - pc=`RESET_PC`, state IDLE.
  - `imem_req`=0, `instr_d`=0, `pc_plus4_d`=0, `valid_d`=0.
  - pending cleared, `fetch_cnt`=0.
- `imem_addr` = pc combinationally.
- `fetch_busy` = IDLE, or (FETCH && !`imem_ack`). Combinational.
- A zero-wait memory (ack in the same cycle as req) sustains one instruction per cycle. Data lands in IF/ID one clock after ack.
- Reset mid-request abandons the transaction. Any late ack is ignored until FETCH is re-entered.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - `fetch_cnt` increments on every IF/ID load with `valid_d`←1.
  - Wraps at 2^32.
- `FETCH_PERF_CNT_EN` undefined: `fetch_cnt` tied to 0 and no counter flops.

## Test plan
- Reset release with `RESET_PC`=0x100 and zero-wait memory:
  - `imem_addr` = 0x100, 0x104, 0x108 on consecutive cycles.
  - `instr_d` follows with one-cycle latency; `valid_d`=1.
- Ack delayed 3 cycles at 0x104:
  - `fetch_busy`=1 for 3 cycles; `imem_addr` holds 0x104.
  - IF/ID loads once.
- Branch with `pc_src_d`=01 and target 0x200, issued during a wait at 0x108:
  - Word returned for 0x108 is discarded (`valid_d`=0).
  - Next `imem_addr`=0x200.
- `stall_f`=`stall_d`=1 asserted in the ack cycle, held 2 cycles:
  - HOLD with `imem_req`=0; `instr_d` unchanged.
  - On release the buffered word enters IF/ID; next address is pc+4.
- `flush_d` and `stall_d` asserted together: `instr_d`=0, `valid_d`=0.
- With `FETCH_PERF_CNT_EN`: 10 sequential fetches plus 1 discarded redirect → `fetch_cnt`=10.
